// File: rtl/debug_tx_dumper_if.sv
// Handshake bundle between the dump engine, its word source and the UART
// transmitter; master is the dump engine itself.
interface debug_tx_dumper_if #(
  parameter int OUTPUT_WORD_LENGTH = 8,
  parameter int LONGITUD_DATO      = 32,
  parameter int ADDR_LENGTH        = 5
);
  logic                          i_start;
  logic [OUTPUT_WORD_LENGTH-1:0] i_tag;
  logic                          i_tx_done;
  logic [LONGITUD_DATO-1:0]      i_dato;
  logic                          o_read_en;
  logic [ADDR_LENGTH-1:0]        o_addr;
  logic                          o_tx_start;
  logic [OUTPUT_WORD_LENGTH-1:0] o_data_tx;
  logic                          o_busy;
  logic                          o_done;

  modport master (
    input  i_start, i_tag, i_tx_done, i_dato,
    output o_read_en, o_addr, o_tx_start, o_data_tx, o_busy, o_done
  );

  modport slave (
    output i_start, i_tag, i_tx_done, i_dato,
    input  o_read_en, o_addr, o_tx_start, o_data_tx, o_busy, o_done
  );
endinterface

// File: rtl/debug_tx_dumper.sv
// Streams a tag byte followed by a block of words from a 1-cycle-latency read
// port to the UART transmitter, most significant byte of each word first.
module debug_tx_dumper #(
  parameter int OUTPUT_WORD_LENGTH = 8,
  parameter int LONGITUD_DATO      = 32,
  parameter int ADDR_LENGTH        = 5,
  parameter int CANT_PALABRAS      = 32
) (
  input logic               i_clock,
  input logic               i_reset,
  debug_tx_dumper_if.master bus
);
  localparam int BYTES_PER_WORD = LONGITUD_DATO / OUTPUT_WORD_LENGTH;
  localparam int BC_W = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam int WC_W = ADDR_LENGTH + 1;
  localparam logic [BC_W-1:0] LAST_BYTE = BC_W'(BYTES_PER_WORD - 1);
  localparam logic [WC_W-1:0] LAST_WORD = WC_W'(CANT_PALABRAS - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SEND_TAG  = 3'd1,
    WAIT_TAG  = 3'd2,
    READ      = 3'd3,
    CAPTURE   = 3'd4,
    SEND      = 3'd5,
    WAIT_DONE = 3'd6,
    FINISH    = 3'd7
  } state_t;

  state_t                        state_r;
  logic [WC_W-1:0]               wc_r;
  logic [BC_W-1:0]               bc_r;
  logic [LONGITUD_DATO-1:0]      shift_r;
  logic [OUTPUT_WORD_LENGTH-1:0] tag_r;
  logic                          read_en_r;
  logic [ADDR_LENGTH-1:0]        addr_r;
  logic                          tx_start_r;
  logic [OUTPUT_WORD_LENGTH-1:0] data_tx_r;
  logic                          busy_r;
  logic                          done_r;

  logic [WC_W-1:0]          wc_inc_s;
  logic [LONGITUD_DATO-1:0] shifted_s;

  assign wc_inc_s  = wc_r + WC_W'(1);
  assign shifted_s = shift_r << OUTPUT_WORD_LENGTH;

  assign bus.o_read_en  = read_en_r;
  assign bus.o_addr     = addr_r;
  assign bus.o_tx_start = tx_start_r;
  assign bus.o_data_tx  = data_tx_r;
  assign bus.o_busy     = busy_r;
  assign bus.o_done     = done_r;

  // Outputs are set on the transition into a state so they are valid while in it;
  // hence a tx_done coincident with tx_start lands in SEND/SEND_TAG and is ignored.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_r    <= IDLE;
      wc_r       <= '0;
      bc_r       <= '0;
      shift_r    <= '0;
      tag_r      <= '0;
      read_en_r  <= 1'b0;
      addr_r     <= '0;
      tx_start_r <= 1'b0;
      data_tx_r  <= '0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      tx_start_r <= 1'b0;
      read_en_r  <= 1'b0;
      done_r     <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.i_start) begin
            tag_r      <= bus.i_tag;
            wc_r       <= '0;
            bc_r       <= '0;
            data_tx_r  <= bus.i_tag;
            tx_start_r <= 1'b1;
            busy_r     <= 1'b1;
            state_r    <= SEND_TAG;
          end else begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        end
        SEND_TAG: state_r <= WAIT_TAG;
        WAIT_TAG: begin
          data_tx_r <= tag_r;
          if (bus.i_tx_done) begin
            read_en_r <= 1'b1;
            addr_r    <= wc_r[ADDR_LENGTH-1:0];
            state_r   <= READ;
          end else begin
            state_r <= WAIT_TAG;
          end
        end
        READ: state_r <= CAPTURE;
        CAPTURE: begin
          shift_r    <= bus.i_dato;
          bc_r       <= '0;
          data_tx_r  <= bus.i_dato[LONGITUD_DATO-1 -: OUTPUT_WORD_LENGTH];
          tx_start_r <= 1'b1;
          state_r    <= SEND;
        end
        SEND: state_r <= WAIT_DONE;
        WAIT_DONE: begin
          if (bus.i_tx_done) begin
            shift_r <= shifted_s;
            bc_r    <= bc_r + BC_W'(1);
            if (bc_r == LAST_BYTE) begin
              wc_r <= wc_inc_s;
              if (wc_r == LAST_WORD) begin
                done_r  <= 1'b1;
                state_r <= FINISH;
              end else begin
                read_en_r <= 1'b1;
                addr_r    <= wc_inc_s[ADDR_LENGTH-1:0];
                state_r   <= READ;
              end
            end else begin
              data_tx_r  <= shifted_s[LONGITUD_DATO-1 -: OUTPUT_WORD_LENGTH];
              tx_start_r <= 1'b1;
              state_r    <= SEND;
            end
          end else begin
            state_r <= WAIT_DONE;
          end
        end
        FINISH: begin
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          state_r   <= IDLE;
          addr_r    <= '0;
          data_tx_r <= '0;
          busy_r    <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_debug_tx_dumper.sv
// Directed bench: a 2-word dumper exercises handshake corner cases and
// mid-frame reset; a 32-word dumper checks the full-address-range frame.
module tb_debug_tx_dumper;
  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  int   st2 = 0, dn2 = 0, st32 = 0, dn32 = 0;
  logic [4:0] addr2[$];
  logic [4:0] addr32[$];
  logic [7:0] exp2 [9] = '{8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD};

  debug_tx_dumper_if #(.OUTPUT_WORD_LENGTH(8), .LONGITUD_DATO(32), .ADDR_LENGTH(5)) a2 ();
  debug_tx_dumper_if #(.OUTPUT_WORD_LENGTH(8), .LONGITUD_DATO(32), .ADDR_LENGTH(5)) a32 ();

  debug_tx_dumper #(.OUTPUT_WORD_LENGTH(8), .LONGITUD_DATO(32), .ADDR_LENGTH(5), .CANT_PALABRAS(2))
    dut2 (.i_clock(clk), .i_reset(rst_n), .bus(a2));
  debug_tx_dumper #(.OUTPUT_WORD_LENGTH(8), .LONGITUD_DATO(32), .ADDR_LENGTH(5), .CANT_PALABRAS(32))
    dut32 (.i_clock(clk), .i_reset(rst_n), .bus(a32));

  always #5 clk = ~clk;

  // Word sources with one cycle of read latency.
  always @(posedge clk) begin
    if (a2.o_read_en)
      a2.i_dato <= (a2.o_addr == 5'd0) ? 32'h11223344 :
                   (a2.o_addr == 5'd1) ? 32'hAABBCCDD : 32'hDEADBEEF;
    if (a32.o_read_en)
      a32.i_dato <= {27'd0, a32.o_addr};
  end

  // Event monitors sampled away from the active edge.
  always @(negedge clk) begin
    if (a2.o_tx_start === 1'b1) st2 = st2 + 1;
    if (a2.o_done === 1'b1) dn2 = dn2 + 1;
    if (a2.o_read_en === 1'b1) addr2.push_back(a2.o_addr);
    if (a32.o_tx_start === 1'b1) st32 = st32 + 1;
    if (a32.o_done === 1'b1) dn32 = dn32 + 1;
    if (a32.o_read_en === 1'b1) addr32.push_back(a32.o_addr);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total = total + 1;
    if (got !== want) begin
      bad = bad + 1;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, want);
    end
  endtask

  task automatic wait_start2(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (a2.o_tx_start === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) chk("a2 start timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_start32(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (a32.o_tx_start === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) chk("a32 start timeout", 32'd0, 32'd1);
  endtask

  task automatic ack2(input int dly, input int width);
    repeat (dly) @(negedge clk);
    a2.i_tx_done = 1'b1;
    repeat (width) @(negedge clk);
    a2.i_tx_done = 1'b0;
  endtask

  task automatic ack32(input int dly);
    repeat (dly) @(negedge clk);
    a32.i_tx_done = 1'b1;
    @(negedge clk);
    a32.i_tx_done = 1'b0;
  endtask

  task automatic pulse_start2(input logic [7:0] tag);
    a2.i_tag   = tag;
    a2.i_start = 1'b1;
    @(negedge clk);
    a2.i_start = 1'b0;
    a2.i_tag   = 8'h00;
  endtask

  task automatic clear_mon2();
    st2 = 0;
    dn2 = 0;
    addr2.delete();
  endtask

  task automatic run_frame2(input logic [7:0] tag);
    bit ok;
    pulse_start2(tag);
    for (int k = 0; k < 9; k++) begin
      wait_start2(ok);
      if (!ok) break;
      chk($sformatf("frame byte%0d", k), a2.o_data_tx, (k == 0) ? tag : exp2[k]);
      ack2(2, 1);
    end
    repeat (3) @(negedge clk);
    chk("frame starts", st2, 9);
    chk("frame dones", dn2, 1);
    chk("frame busy low", a2.o_busy, 0);
    chk("frame reads", addr2.size(), 2);
  endtask

  initial begin
    bit         ok;
    int         glitch, seen, errs;
    logic [7:0] want, last;
    clk = 1'b0;
    rst_n = 1'b0;
    a2.i_start = 1'b0;  a2.i_tag = 8'h00;  a2.i_tx_done = 1'b0;
    a32.i_start = 1'b0; a32.i_tag = 8'h00; a32.i_tx_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst busy", a2.o_busy, 0);
    chk("rst tx_start", a2.o_tx_start, 0);
    chk("rst data_tx", a2.o_data_tx, 0);
    chk("rst addr", a2.o_addr, 0);
    chk("rst read_en", a2.o_read_en, 0);
    chk("rst done", a2.o_done, 0);
    rst_n = 1'b1;
    @(negedge clk);
    clear_mon2();

    // Frame 1 with stalls, spurious requests and ignored done pulses.
    pulse_start2(8'h02);
    chk("busy rise", a2.o_busy, 1);
    for (int k = 0; k < 9; k++) begin
      wait_start2(ok);
      if (!ok) break;
      chk($sformatf("f1 byte%0d", k), a2.o_data_tx, exp2[k]);
      if (k == 1) begin
        a2.i_tag = 8'h55;
        a2.i_start = 1'b1;
        @(negedge clk);
        a2.i_start = 1'b0;
        a2.i_tag = 8'h00;
        ack2(9, 1);
      end else if (k == 2) begin
        glitch = 0;
        repeat (500) begin
          @(negedge clk);
          if (a2.o_tx_start !== 1'b0 || a2.o_data_tx !== 8'h22) glitch = glitch + 1;
        end
        chk("stall hold", glitch, 0);
        ack2(1, 1);
      end else if (k == 3) begin
        a2.i_tx_done = 1'b1;
        @(negedge clk);
        a2.i_tx_done = 1'b0;
        seen = st2;
        repeat (5) @(negedge clk);
        chk("coincident done ignored", st2 - seen, 0);
        ack2(10, 1);
      end else if (k == 4) begin
        ack2(10, 2);
      end else begin
        ack2(10, 1);
      end
    end
    repeat (3) @(negedge clk);
    chk("f1 starts", st2, 9);
    chk("f1 dones", dn2, 1);
    chk("f1 busy low", a2.o_busy, 0);
    chk("f1 reads", addr2.size(), 2);
    if (addr2.size() == 2) begin
      chk("f1 addr0", addr2[0], 0);
      chk("f1 addr1", addr2[1], 1);
    end

    // Reset in the middle of the second word.
    clear_mon2();
    pulse_start2(8'h7E);
    for (int k = 0; k < 5; k++) begin
      wait_start2(ok);
      if (!ok) break;
      ack2(3, 1);
    end
    wait_start2(ok);
    chk("f2 byte5", a2.o_data_tx, 8'hAA);
    rst_n = 1'b0;
    #1;
    chk("async rst tx_start", a2.o_tx_start, 0);
    chk("async rst data_tx", a2.o_data_tx, 0);
    chk("async rst busy", a2.o_busy, 0);
    chk("async rst addr", a2.o_addr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post rst idle", a2.o_busy, 0);
    clear_mon2();
    run_frame2(8'h03);

    // Full 32-word frame, data equals address.
    st32 = 0;
    dn32 = 0;
    addr32.delete();
    a32.i_tag = 8'hA5;
    a32.i_start = 1'b1;
    @(negedge clk);
    a32.i_start = 1'b0;
    errs = 0;
    last = 8'h00;
    for (int k = 0; k < 129; k++) begin
      wait_start32(ok);
      if (!ok) break;
      if (k == 0) want = 8'hA5;
      else if (((k - 1) % 4) == 3) want = 8'((k - 1) / 4);
      else want = 8'h00;
      if (a32.o_data_tx !== want) errs = errs + 1;
      last = a32.o_data_tx;
      ack32(1);
    end
    chk("f32 bytes", errs, 0);
    chk("f32 last byte", last, 8'h1F);
    repeat (20) @(negedge clk);
    chk("f32 starts", st32, 129);
    chk("f32 dones", dn32, 1);
    chk("f32 busy low", a32.o_busy, 0);
    chk("f32 reads", addr32.size(), 32);
    errs = 0;
    foreach (addr32[i]) if (addr32[i] !== 5'(i)) errs = errs + 1;
    chk("f32 addr order", errs, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
